// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: default word width and FSM state encodings.
package dmem_responder_pkg;

  localparam int unsigned DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Pipeline <-> data-memory bus; mem_misalign exists only when DMEM_MISALIGN_TRAP_EN is defined.
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W
);

  logic              MemRead;
  logic              MemWrite;
  logic [31:0]       address;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] read_data;
  logic              mem_stall;
  logic              mem_done;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic              mem_misalign;
`endif

  modport master (
    output MemRead, MemWrite, address, writeData,
`ifdef DMEM_MISALIGN_TRAP_EN
    input  mem_misalign,
`endif
    input  read_data, mem_stall, mem_done
  );

  modport slave (
    input  MemRead, MemWrite, address, writeData,
`ifdef DMEM_MISALIGN_TRAP_EN
    output mem_misalign,
`endif
    output read_data, mem_stall, mem_done
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage for the data memory: synchronous write port, asynchronous read port, never cleared.
module dmem_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: stalls the pipeline for WAIT_CYCLES per access, then pulses mem_done.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = DMEM_DATA_W
) (
  input  logic           CLK,
  input  logic           RST,
  dmem_responder_if.slave bus
);

  localparam int unsigned     CNT_W    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 1) ? WAIT_CYCLES - 2 : 0);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               req;
  logic               misalign;
  logic               stall;
  logic               done;
  logic               we;
  logic               rd_load;
  logic [ADDR_W-1:0]  idx;
  logic [DATA_W-1:0]  rdata;
  logic [DATA_W-1:0]  read_data_q;
  logic               unused_addr;

  assign req         = bus.MemRead | bus.MemWrite;
  assign idx         = bus.address[ADDR_W+1:2];
  assign unused_addr = ^{bus.address[31:ADDR_W+2], bus.address[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign         = !RST && (state == IDLE) && req && (bus.address[1:0] != 2'b00);
  assign bus.mem_misalign = misalign;
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // With WAIT_CYCLES=0 the FSM never leaves IDLE; accesses complete in the request cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req && !misalign && (WAIT_CYCLES != 0)) begin
          if (WAIT_CYCLES == 1) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (!req)                state_next = IDLE;
        else if (cnt == '0)      state_next = RESP;
        else                     cnt_next   = cnt - CNT_W'(1);
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset suppresses stall/done at once so an in-flight access is dropped uncommitted.
  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (req && !misalign) begin
            if (WAIT_CYCLES == 0) done  = 1'b1;
            else                  stall = 1'b1;
          end
        end
        BUSY:    stall = 1'b1;
        RESP:    done  = 1'b1;
        default: ;
      endcase
    end
  end

  assign we      = done & bus.MemWrite;
  assign rd_load = done & bus.MemRead & ~bus.MemWrite;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (CLK),
    .we    (we),
    .waddr (idx),
    .wdata (bus.writeData),
    .raddr (idx),
    .rdata (rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          read_data_q <= '0;
    else if (rd_load) read_data_q <= rdata;
  end

  assign bus.read_data = read_data_q;
  assign bus.mem_stall = stall;
  assign bus.mem_done  = done;

endmodule
